// File: rtl/eth_crc_pkg.sv
// Ethernet CRC-32 constants, byte-step helper and the FCS-append state type.
// Shared by the TX appender and any RX checker that reuses crc32_d64.
package eth_crc_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

    typedef enum logic {
        ST_PASS  = 1'b0,
        ST_EXTRA = 1'b1
    } state_t;

    // One reflected CRC-32 step over a single byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC32_POLY_REFL) : (r >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/append_crc_if.sv
// AXI-Stream beat bundle used for both the frame input and the FCS-appended output.
interface append_crc_if #(
    parameter int DATA_BYTES = 8,
    parameter int DATA_BITS  = DATA_BYTES * 8
);
    logic [DATA_BITS-1:0]  tdata;
    logic                  tvalid;
    logic                  tready;
    logic [DATA_BYTES-1:0] tkeep;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, tvalid, tkeep, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/crc32_d64.sv
// Combinational CRC-32 update over the kept bytes of a 64-bit beat, byte 0 first.
module crc32_d64
    import eth_crc_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [63:0] data,
    input  logic [7:0]  keep,
    output logic [31:0] crc_out
);

    logic [31:0] w_acc;

    always_comb begin
        w_acc = crc_in;
        for (int b = 0; b < 8; b++) begin
            if (keep[b]) begin
                w_acc = crc32_byte(w_acc, data[8*b +: 8]);
            end
        end
    end

    assign crc_out = w_acc;

endmodule

// File: rtl/append_crc.sv
// Appends the Ethernet FCS to each AXI-Stream frame; one registered output stage (1 cycle).
// Input ready only when the output register is free and no overflow beat is pending.
module append_crc
    import eth_crc_pkg::*;
#(
    parameter int DATA_BYTES = 8,
    parameter int DATA_BITS  = DATA_BYTES * 8
) (
    input  logic         clock,
    input  logic         aresetn,
    append_crc_if.slave  saxis,
    append_crc_if.master maxis,
    output logic [31:0]  crc
);

    state_t                r_state;
    logic [31:0]           r_crc_run;
    logic                  r_vld;
    logic [DATA_BITS-1:0]  r_dat;
    logic [DATA_BYTES-1:0] r_keep;
    logic                  r_last;
    logic                  r_user;
    logic [31:0]           r_crc;
    logic [31:0]           r_ext_dat;
    logic [3:0]            r_ext_keep;
    logic                  r_ext_user;
    logic [31:0]           r_ext_fcs;

    logic                  w_fire;
    logic                  w_out_ok;
    logic [31:0]           w_crc_next;
    logic [31:0]           w_fcs;
    logic [3:0]            w_k;
    logic [63:0]           w_last_dat;
    logic [7:0]            w_last_keep;
    logic [31:0]           w_ext_dat;
    logic [3:0]            w_ext_keep;

    assign w_out_ok     = !r_vld || maxis.tready;
    assign saxis.tready = w_out_ok && (r_state == ST_PASS);
    assign w_fire       = saxis.tvalid && saxis.tready;

    crc32_d64 u_crc (
        .crc_in  (r_crc_run),
        .data    (saxis.tdata),
        .keep    (saxis.tkeep),
        .crc_out (w_crc_next)
    );

    assign w_fcs = w_crc_next ^ CRC32_XOROUT;

    // Last-beat merge: payload in lanes 0..k-1, FCS bytes follow; overflow goes to the extra beat.
    always_comb begin
        w_k         = '0;
        w_last_dat  = '0;
        w_last_keep = '0;
        w_ext_keep  = '0;
        for (int i = 0; i < 8; i++) begin
            w_k = w_k + 4'(saxis.tkeep[i]);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < int'(w_k)) begin
                w_last_dat[8*i +: 8] = saxis.tdata[8*i +: 8];
                w_last_keep[i]       = 1'b1;
            end else if (i < int'(w_k) + 4) begin
                w_last_dat[8*i +: 8] = w_fcs[8*(i - int'(w_k)) +: 8];
                w_last_keep[i]       = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            w_ext_keep[i] = (i < int'(w_k) - 4);
        end
        w_ext_dat = w_fcs >> (8 * (8 - int'(w_k)));
    end

    always_ff @(posedge clock) begin
        if (!aresetn) begin
            r_state    <= ST_PASS;
            r_crc_run  <= CRC32_INIT;
            r_vld      <= 1'b0;
            r_dat      <= '0;
            r_keep     <= '0;
            r_last     <= 1'b0;
            r_user     <= 1'b0;
            r_crc      <= '0;
            r_ext_dat  <= '0;
            r_ext_keep <= '0;
            r_ext_user <= 1'b0;
            r_ext_fcs  <= '0;
        end else if (w_fire) begin
            r_vld  <= 1'b1;
            r_user <= saxis.tuser;
            if (!saxis.tlast) begin
                r_dat     <= saxis.tdata;
                r_keep    <= saxis.tkeep;
                r_last    <= 1'b0;
                r_crc_run <= w_crc_next;
            end else begin
                r_crc_run <= CRC32_INIT;
                r_dat     <= w_last_dat;
                r_keep    <= w_last_keep;
                if (w_k > 4'd4) begin
                    r_last     <= 1'b0;
                    r_ext_dat  <= w_ext_dat;
                    r_ext_keep <= w_ext_keep;
                    r_ext_user <= saxis.tuser;
                    r_ext_fcs  <= w_fcs;
                    r_state    <= ST_EXTRA;
                end else begin
                    r_last <= 1'b1;
                    r_crc  <= w_fcs;
                end
            end
        end else if (r_state == ST_EXTRA && w_out_ok) begin
            r_vld   <= 1'b1;
            r_dat   <= {32'h0, r_ext_dat};
            r_keep  <= {4'h0, r_ext_keep};
            r_last  <= 1'b1;
            r_user  <= r_ext_user;
            r_crc   <= r_ext_fcs;
            r_state <= ST_PASS;
        end else if (maxis.tready) begin
            r_vld <= 1'b0;
        end
    end

    assign maxis.tvalid = r_vld;
    assign maxis.tdata  = r_dat;
    assign maxis.tkeep  = r_keep;
    assign maxis.tlast  = r_last;
    assign maxis.tuser  = r_user;
    assign crc          = r_crc;

endmodule

// File: tb/tb_append_crc.sv
// Self-checking bench for append_crc: scoreboard of expected output beats built from a frame-level FCS model.
module tb_append_crc;

    logic clock = 1'b0;
    logic aresetn = 1'b0;
    always #5 clock = ~clock;

    append_crc_if s_if ();
    append_crc_if m_if ();
    logic [31:0] crc;

    append_crc dut (
        .clock   (clock),
        .aresetn (aresetn),
        .saxis   (s_if),
        .maxis   (m_if),
        .crc     (crc)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic [31:0] fcs;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  pl[$];
    bit          us[$];
    int          n_checks = 0;
    int          n_pass = 0;
    bit          rdy_rand = 1'b0;
    bit          rdy_val = 1'b1;
    logic [63:0] last_dat;
    logic [7:0]  last_keep;

    // Sink ready, changed just after each rising edge
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            m_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_fcs();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (pl[i]) begin
            c = c ^ {24'h0, pl[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [63:0] keep_mask(input logic [7:0] k);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    // Output monitor: scoreboard compare and hold-while-stalled check
    bit          prev_stall = 1'b0;
    logic [74:0] prev_sig;
    beat_t       e;
    always @(negedge clock) begin
        if (aresetn && prev_stall) begin
            n_checks++;
            if ({m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser} !== prev_sig)
                $display("FAIL stall_stable: got %h required %h",
                         {m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser}, prev_sig);
            else n_pass++;
        end
        prev_stall = aresetn && m_if.tvalid && !m_if.tready;
        prev_sig   = {m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
        if (aresetn && m_if.tvalid && m_if.tready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_beat: got data=%h keep=%h last=%b, required no beat",
                         m_if.tdata, m_if.tkeep, m_if.tlast);
            end else begin
                e = exp_q.pop_front();
                if (m_if.tkeep !== e.keep || m_if.tlast !== e.last || m_if.tuser !== e.user ||
                    (m_if.tdata & keep_mask(e.keep)) !== e.data)
                    $display("FAIL beat: got data=%h keep=%h last=%b user=%b required data=%h keep=%h last=%b user=%b",
                             m_if.tdata & keep_mask(e.keep), m_if.tkeep, m_if.tlast, m_if.tuser,
                             e.data, e.keep, e.last, e.user);
                else n_pass++;
                if (e.last) begin
                    n_checks++;
                    if (crc !== e.fcs) $display("FAIL crc_out: got %h required %h", crc, e.fcs);
                    else n_pass++;
                end
            end
            last_dat  = m_if.tdata;
            last_keep = m_if.tkeep;
        end
    end

    task automatic make_frame(input int n, input bit rand_user);
        pl.delete();
        us.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
        for (int j = 0; j < (n + 7) / 8; j++) us.push_back(rand_user ? 1'($urandom_range(0, 1)) : 1'b0);
    endtask

    // Pushes the expected output beats, then drives the frame; returns cycles spent waiting on ready
    task automatic send_frame(output int stalls);
        logic [7:0]  allb[$];
        logic [31:0] fcs;
        beat_t       x;
        int          n, nin, nout, w;
        bit          f;
        n    = pl.size();
        nin  = (n + 7) / 8;
        fcs  = model_fcs();
        allb = pl;
        for (int i = 0; i < 4; i++) allb.push_back(fcs[8*i +: 8]);
        nout = (allb.size() + 7) / 8;
        for (int j = 0; j < nout; j++) begin
            x.data = '0;
            x.keep = '0;
            for (int b = 0; b < 8; b++) begin
                if (8*j + b < allb.size()) begin
                    x.data[8*b +: 8] = allb[8*j + b];
                    x.keep[b]        = 1'b1;
                end
            end
            x.last = (j == nout - 1);
            x.user = (j < nin - 1) ? us[j] : us[nin - 1];
            x.fcs  = fcs;
            exp_q.push_back(x);
        end
        stalls = 0;
        for (int j = 0; j < nin; j++) begin
            s_if.tdata = '0;
            s_if.tkeep = '0;
            for (int b = 0; b < 8; b++) begin
                if (8*j + b < n) begin
                    s_if.tdata[8*b +: 8] = pl[8*j + b];
                    s_if.tkeep[b]        = 1'b1;
                end
            end
            s_if.tlast  = (j == nin - 1);
            s_if.tuser  = us[j];
            s_if.tvalid = 1'b1;
            w = 0;
            do begin
                @(negedge clock);
                f = s_if.tready;
                @(posedge clock);
                #1;
                if (!f) begin
                    w++;
                    stalls++;
                end
            end while (!f && w < 2000);
            if (!f) begin
                n_checks++;
                $display("FAIL handshake_timeout: tready stayed %b, required 1", s_if.tready);
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 20000) begin
            @(posedge clock);
            w++;
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drain: %0d beats still expected, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        aresetn     = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++; if (m_if.tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b required 0", m_if.tvalid); else n_pass++;
        n_checks++; if (m_if.tlast !== 1'b0) $display("FAIL rst_tlast: got %b required 0", m_if.tlast); else n_pass++;
        n_checks++; if (m_if.tuser !== 1'b0) $display("FAIL rst_tuser: got %b required 0", m_if.tuser); else n_pass++;
        n_checks++; if (m_if.tdata !== 64'h0) $display("FAIL rst_tdata: got %h required 0", m_if.tdata); else n_pass++;
        n_checks++; if (m_if.tkeep !== 8'h0) $display("FAIL rst_tkeep: got %h required 0", m_if.tkeep); else n_pass++;
        n_checks++; if (crc !== 32'h0) $display("FAIL rst_crc: got %h required 0", crc); else n_pass++;
        n_checks++; if (s_if.tready !== 1'b1) $display("FAIL rst_tready: got %b required 1", s_if.tready); else n_pass++;
        @(posedge clock);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic test_check_value();
        int st;
        pl.delete();
        us.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'(49 + i));
        us.push_back(1'b0);
        us.push_back(1'b0);
        send_frame(st);
        drain();
        n_checks++; if (crc !== 32'hCBF4_3926) $display("FAIL check_crc: got %h required cbf43926", crc); else n_pass++;
        n_checks++; if (last_keep !== 8'h1F) $display("FAIL check_keep: got %h required 1f", last_keep); else n_pass++;
        n_checks++;
        if ((last_dat & 64'h0000_00FF_FFFF_FFFF) !== 64'h0000_00CB_F439_2639)
            $display("FAIL check_bytes: got %h required 000000cbf4392639", last_dat & 64'h0000_00FF_FFFF_FFFF);
        else n_pass++;
    endtask

    task automatic test_eight_byte();
        int st;
        make_frame(8, 1'b0);
        send_frame(st);
        @(negedge clock);
        n_checks++; if (s_if.tready !== 1'b0) $display("FAIL extra_bubble: got tready %b required 0", s_if.tready); else n_pass++;
        @(negedge clock);
        n_checks++; if (s_if.tready !== 1'b1) $display("FAIL extra_bubble_end: got tready %b required 1", s_if.tready); else n_pass++;
        drain();
        n_checks++; if (last_keep !== 8'h0F) $display("FAIL extra_keep: got %h required 0f", last_keep); else n_pass++;
    endtask

    task automatic test_fourteen();
        int st;
        make_frame(14, 1'b0);
        us[1] = 1'b1;
        send_frame(st);
        drain();
        n_checks++; if (last_keep !== 8'h03) $display("FAIL fourteen_keep: got %h required 03", last_keep); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int st, total;
        total = 0;
        for (int f = 0; f < 10; f++) begin
            make_frame(4, 1'b1);
            send_frame(st);
            total += st;
        end
        drain();
        n_checks++; if (total !== 0) $display("FAIL b2b_stalls: got %0d stall cycles required 0", total); else n_pass++;
    endtask

    task automatic test_reset_extra();
        int st;
        make_frame(8, 1'b0);
        s_if.tdata  = {pl[7], pl[6], pl[5], pl[4], pl[3], pl[2], pl[1], pl[0]};
        s_if.tkeep  = 8'hFF;
        s_if.tlast  = 1'b1;
        s_if.tuser  = 1'b0;
        s_if.tvalid = 1'b1;
        @(posedge clock);
        #1;
        s_if.tvalid = 1'b0;
        n_checks++; if (s_if.tready !== 1'b0) $display("FAIL rstx_in_extra: got tready %b required 0", s_if.tready); else n_pass++;
        aresetn = 1'b0;
        @(posedge clock);
        #1;
        n_checks++; if (m_if.tvalid !== 1'b0) $display("FAIL rstx_tvalid: got %b required 0", m_if.tvalid); else n_pass++;
        n_checks++; if (s_if.tready !== 1'b1) $display("FAIL rstx_tready: got %b required 1", s_if.tready); else n_pass++;
        aresetn = 1'b1;
        make_frame(13, 1'b1);
        send_frame(st);
        drain();
    endtask

    task automatic test_random();
        int st;
        rdy_rand = 1'b1;
        for (int f = 0; f < 150; f++) begin
            make_frame($urandom_range(1, 1500), 1'b1);
            send_frame(st);
        end
        drain();
        rdy_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_check_value();
        test_eight_byte();
        test_fourteen();
        test_back_to_back();
        test_reset_extra();
        test_random();
        repeat (4) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
